dual_port_ram: RTL and testbench
================================

DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
REQ-001 SHALL have parameter BITS, default 32, data word width; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR, default 9, address width.
REQ-003 SHALL have parameter RAMSIZE, default 512, number of words; RAMSIZE <= 2**ADDR.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port a_en  input  1  port A request strobe.
REQ-007 SHALL have port a_write  input  1  port A op: 1 write, 0 read.
REQ-008 SHALL have port a_be  input  BITS/8  port A byte write enables.
REQ-009 SHALL have port a_addr  input  ADDR  port A word address.
REQ-010 SHALL have port a_din  input  BITS  port A write data.
REQ-011 SHALL have port a_dout  output  BITS  port A registered read data.
REQ-012 SHALL have port a_valid  output  1  port A read data valid pulse.
REQ-013 SHALL have port b_en  input  1  port B read request strobe.
REQ-014 SHALL have port b_addr  input  ADDR  port B word address.
REQ-015 SHALL have port b_dout  output  BITS  port B registered read data.
REQ-016 SHALL have port b_valid  output  1  port B read data valid pulse.
REQ-017 SHALL have port busy  output  1  high while requests are not accepted.
REQ-018 SHALL have port addr_err  output  1  pulse on any accepted request with address >= RAMSIZE.

Function
REQ-019 SHALL accept a request on a port only when its en=1 and busy=0 at the rising edge; otherwise the request is ignored with no side effects.
REQ-020 SHALL, on an accepted port A write, update only the bytes whose a_be bit is 1; a_be=0 writes nothing but is still accepted.
REQ-021 SHALL, on an accepted read on either port, drive dout with the word one cycle later and pulse valid high for exactly that cycle (latency 1).
REQ-022 SHALL hold dout at its last value while valid=0.
REQ-023 SHALL, when a port A write and a port B read target the same address in the same cycle, return the old (pre-write) word on b_dout.
REQ-024 SHALL, for an accepted request with address >= RAMSIZE, suppress the write, return 0 with valid=1 for reads, and pulse addr_err the following cycle.
REQ-025 SHALL allow port A and port B to be accepted in the same cycle, independently.
REQ-026 SHALL implement FSM states INIT and READY; busy=1 in INIT, 0 in READY.

Reset
REQ-027 SHALL, while reset_n=0, force a_dout=0, b_dout=0, a_valid=0, b_valid=0, addr_err=0, and FSM to INIT.
REQ-028 SHALL abandon any in-flight read when reset asserts mid-operation; no valid pulse follows reset release.

Configuration
REQ-029 SHALL, with RAM_CLEAR_EN defined, sweep in INIT after reset release, writing 0 to one word per cycle from address 0 to RAMSIZE-1, then enter READY (busy high for RAMSIZE cycles).
REQ-030 SHALL, with RAM_CLEAR_EN undefined, move INIT -> READY on the first edge after reset release (busy high one cycle); memory contents are then undefined.

Structure
REQ-031 SHALL place the FSM state type and the INIT/READY encodings in package dual_port_ram_pkg.
REQ-032 SHALL implement the storage array plus byte-enable write logic as sub-module ram_bank; dual_port_ram holds FSM, clear counter, range checks and output registers.

Verification
REQ-033 SHALL cover: with RAM_CLEAR_EN, reset release -> busy high 512 cycles, then reads of addresses 0, 3, 511 return 0.
REQ-034 SHALL cover: A write 0x00000005 to 0x003, be=0xF, then B read 0x003 -> b_dout=0x00000005 with b_valid one cycle after accept.
REQ-035 SHALL cover: A write 0xAABBCCDD to 0x010 be=0xF, then write 0x11223344 be=0x5 -> A read 0x010 returns 0xAA22CC44.
REQ-036 SHALL cover: same-cycle A write 0x7 and B read at 0x020 holding 0x1 -> b_dout=0x1, later read returns 0x7.
REQ-037 SHALL cover: A read at 0x1FF with RAMSIZE=256 -> a_dout=0, a_valid=1, addr_err=1 one cycle later; memory unchanged.
REQ-038 SHALL cover: reset_n pulsed low the cycle after an accepted read -> no a_valid pulse, all outputs 0, busy=1 after release.

Source files
------------

// File: rtl/dual_port_ram_pkg.sv
// Shared types for the dual-port RAM: controller state encoding and byte geometry.
package dual_port_ram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/dual_port_ram_bank.sv
// Storage array with one byte-enabled write port and two combinational read ports.
module ram_bank
  import dual_port_ram_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int AW    = 9,
  parameter int DEPTH = 512
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [BITS/BYTE_W-1:0] wr_be,
  input  logic [AW-1:0]          wr_addr,
  input  logic [BITS-1:0]        wr_data,
  input  logic [AW-1:0]          rd_a_addr,
  output logic [BITS-1:0]        rd_a_data,
  input  logic [AW-1:0]          rd_b_addr,
  output logic [BITS-1:0]        rd_b_data
);

  localparam int NB = BITS / BYTE_W;

  logic [BITS-1:0] mem_r [0:DEPTH-1];

  // Byte-lane write; the array itself is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem_r[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Reads are combinational so a same-edge register in the parent captures pre-write data.
  assign rd_a_data = mem_r[rd_a_addr];
  assign rd_b_data = mem_r[rd_b_addr];

endmodule

// File: rtl/dual_port_ram.sv
// Dual-port RAM controller: port A read/write, port B read, range checking, registered outputs.
// Optional build macro RAM_CLEAR_EN: zero the whole array after reset before accepting requests.
module dual_port_ram
  import dual_port_ram_pkg::*;
#(
  parameter int BITS    = 32,
  parameter int ADDR    = 9,
  parameter int RAMSIZE = 512
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   a_en,
  input  logic                   a_write,
  input  logic [BITS/BYTE_W-1:0] a_be,
  input  logic [ADDR-1:0]        a_addr,
  input  logic [BITS-1:0]        a_din,
  output logic [BITS-1:0]        a_dout,
  output logic                   a_valid,
  input  logic                   b_en,
  input  logic [ADDR-1:0]        b_addr,
  output logic [BITS-1:0]        b_dout,
  output logic                   b_valid,
  output logic                   busy,
  output logic                   addr_err
);

  localparam int NB = BITS / BYTE_W;
  localparam int IW = (RAMSIZE > 1) ? $clog2(RAMSIZE) : 1;
  // One bit wider than the address so RAMSIZE == 2**ADDR still compares correctly.
  localparam logic [ADDR:0] RAM_LIMIT = (ADDR+1)'(RAMSIZE);

  state_t          state_r;
  state_t          state_next_s;
  logic            busy_r;
  logic            ready_s;
  logic            a_acc_s;
  logic            b_acc_s;
  logic            a_oor_s;
  logic            b_oor_s;
  logic            a_rd_s;
  logic            wr_en_s;
  logic [NB-1:0]   wr_be_s;
  logic [IW-1:0]   wr_addr_s;
  logic [BITS-1:0] wr_data_s;
  logic [BITS-1:0] a_rdata_s;
  logic [BITS-1:0] b_rdata_s;
  logic [BITS-1:0] a_dout_r;
  logic [BITS-1:0] b_dout_r;
  logic            a_valid_r;
  logic            b_valid_r;
  logic            addr_err_r;

`ifdef RAM_CLEAR_EN
  localparam logic [ADDR-1:0] RAM_LAST = ADDR'(RAMSIZE - 1);
  logic [ADDR-1:0] clr_cnt_r;

  // Sweep pointer for the post-reset clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt_r <= {ADDR{1'b0}};
    end else if (state_r == INIT) begin
      clr_cnt_r <= clr_cnt_r + ADDR'(1);
    end else begin
      clr_cnt_r <= clr_cnt_r;
    end
  end
`endif

  // Next-state logic: INIT either sweeps the array or lasts a single cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      INIT: begin
`ifdef RAM_CLEAR_EN
        if (clr_cnt_r == RAM_LAST) begin
          state_next_s = READY;
        end else begin
          state_next_s = INIT;
        end
`else
        state_next_s = READY;
`endif
      end
      READY:   state_next_s = READY;
      default: state_next_s = INIT;
    endcase
  end

  // State register; busy is registered alongside so it tracks the state exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= INIT;
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != READY);
    end
  end

  // Request acceptance and range checks.
  always_comb begin
    ready_s = (state_r == READY);
    a_acc_s = a_en & ready_s;
    b_acc_s = b_en & ready_s;
    a_oor_s = ({1'b0, a_addr} >= RAM_LIMIT);
    b_oor_s = ({1'b0, b_addr} >= RAM_LIMIT);
    a_rd_s  = a_acc_s & ~a_write;
  end

  // Write-port mux: clear sweep during INIT, otherwise in-range port A writes.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_be_s   = a_be;
    wr_addr_s = a_addr[IW-1:0];
    wr_data_s = a_din;
    if (state_r == INIT) begin
`ifdef RAM_CLEAR_EN
      wr_en_s   = 1'b1;
      wr_be_s   = {NB{1'b1}};
      wr_addr_s = clr_cnt_r[IW-1:0];
      wr_data_s = {BITS{1'b0}};
`else
      wr_en_s   = 1'b0;
`endif
    end else begin
      wr_en_s = a_acc_s & a_write & ~a_oor_s;
    end
  end

  ram_bank #(
    .BITS  (BITS),
    .AW    (IW),
    .DEPTH (RAMSIZE)
  ) u_bank (
    .clk       (clk),
    .wr_en     (wr_en_s),
    .wr_be     (wr_be_s),
    .wr_addr   (wr_addr_s),
    .wr_data   (wr_data_s),
    .rd_a_addr (a_addr[IW-1:0]),
    .rd_a_data (a_rdata_s),
    .rd_b_addr (b_addr[IW-1:0]),
    .rd_b_data (b_rdata_s)
  );

  // Output registers: dout holds between reads, out-of-range reads return zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_dout_r   <= {BITS{1'b0}};
      b_dout_r   <= {BITS{1'b0}};
      a_valid_r  <= 1'b0;
      b_valid_r  <= 1'b0;
      addr_err_r <= 1'b0;
    end else begin
      a_valid_r  <= a_rd_s;
      b_valid_r  <= b_acc_s;
      addr_err_r <= (a_acc_s & a_oor_s) | (b_acc_s & b_oor_s);
      if (a_rd_s) begin
        a_dout_r <= a_oor_s ? {BITS{1'b0}} : a_rdata_s;
      end else begin
        a_dout_r <= a_dout_r;
      end
      if (b_acc_s) begin
        b_dout_r <= b_oor_s ? {BITS{1'b0}} : b_rdata_s;
      end else begin
        b_dout_r <= b_dout_r;
      end
    end
  end

  assign a_dout   = a_dout_r;
  assign b_dout   = b_dout_r;
  assign a_valid  = a_valid_r;
  assign b_valid  = b_valid_r;
  assign busy     = busy_r;
  assign addr_err = addr_err_r;

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed self-checking bench for dual_port_ram (RAMSIZE=256 so 0x1FF is out of range).
module tb_dual_port_ram;

  logic        clk;
  logic        reset_n;
  logic        a_en;
  logic        a_write;
  logic [3:0]  a_be;
  logic [8:0]  a_addr;
  logic [31:0] a_din;
  logic [31:0] a_dout;
  logic        a_valid;
  logic        b_en;
  logic [8:0]  b_addr;
  logic [31:0] b_dout;
  logic        b_valid;
  logic        busy;
  logic        addr_err;

  int checks = 0;
  int errors = 0;
  int n;

  dual_port_ram #(.BITS(32), .ADDR(9), .RAMSIZE(256)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_en(a_en), .a_write(a_write), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout), .a_valid(a_valid),
    .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout), .b_valid(b_valid),
    .busy(busy), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_wr(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] be);
    a_en = 1'b1; a_write = 1'b1; a_addr = addr; a_din = data; a_be = be;
    tick();
    a_en = 1'b0; a_write = 1'b0;
  endtask

  task automatic a_rd(input logic [8:0] addr);
    a_en = 1'b1; a_write = 1'b0; a_addr = addr;
    tick();
    a_en = 1'b0;
  endtask

  task automatic b_rd(input logic [8:0] addr);
    b_en = 1'b1; b_addr = addr;
    tick();
    b_en = 1'b0;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 2000) begin
      cycles++;
      tick();
    end
    check("ready_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; a_en = 1'b0; a_write = 1'b0; a_be = 4'h0; a_addr = 9'h000;
    a_din = 32'h0; b_en = 1'b0; b_addr = 9'h000;
    tick(); tick();
    check("rst_a_dout", a_dout, 32'h0);
    check("rst_b_dout", b_dout, 32'h0);
    check("rst_a_valid", {31'd0, a_valid}, 32'd0);
    check("rst_b_valid", {31'd0, b_valid}, 32'd0);
    check("rst_addr_err", {31'd0, addr_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);

    reset_n = 1'b1;
    wait_ready(n);
`ifdef RAM_CLEAR_EN
    check("busy_len", n, 32'd256);
    a_rd(9'h000); check("clr_0", a_dout, 32'h0); check("clr_0_v", {31'd0, a_valid}, 32'd1);
    a_rd(9'h003); check("clr_3", a_dout, 32'h0);
    b_rd(9'h0FF); check("clr_ff", b_dout, 32'h0); check("clr_ff_v", {31'd0, b_valid}, 32'd1);
`else
    check("busy_len", n, 32'd1);
`endif

    // Write then read on port B
    a_wr(9'h003, 32'h0000_0005, 4'hF);
    check("wr_no_valid", {31'd0, a_valid}, 32'd0);
    b_rd(9'h003);
    check("b_rd3", b_dout, 32'h0000_0005);
    check("b_rd3_v", {31'd0, b_valid}, 32'd1);
    check("b_rd3_err", {31'd0, addr_err}, 32'd0);
    tick();
    check("b_valid_pulse", {31'd0, b_valid}, 32'd0);
    check("b_dout_hold", b_dout, 32'h0000_0005);

    // Byte enables
    a_wr(9'h010, 32'hAABB_CCDD, 4'hF);
    a_wr(9'h010, 32'h1122_3344, 4'h5);
    a_wr(9'h010, 32'hFFFF_FFFF, 4'h0);
    a_rd(9'h010);
    check("be_merge", a_dout, 32'hAA22_CC44);
    check("be_merge_v", {31'd0, a_valid}, 32'd1);

    // Same-cycle write / read collision returns old data
    a_wr(9'h020, 32'h0000_0001, 4'hF);
    a_en = 1'b1; a_write = 1'b1; a_addr = 9'h020; a_din = 32'h7; a_be = 4'hF;
    b_en = 1'b1; b_addr = 9'h020;
    tick();
    a_en = 1'b0; a_write = 1'b0; b_en = 1'b0;
    check("rbw_old", b_dout, 32'h0000_0001);
    b_rd(9'h020);
    check("rbw_new", b_dout, 32'h0000_0007);

    // Out-of-range read and write
    a_rd(9'h1FF);
    check("oor_rd_data", a_dout, 32'h0);
    check("oor_rd_v", {31'd0, a_valid}, 32'd1);
    check("oor_rd_err", {31'd0, addr_err}, 32'd1);
    tick();
    check("oor_err_pulse", {31'd0, addr_err}, 32'd0);
    a_wr(9'h103, 32'hDEAD_BEEF, 4'hF);
    check("oor_wr_err", {31'd0, addr_err}, 32'd1);
    b_rd(9'h100);
    check("oor_b_rd", b_dout, 32'h0);
    check("oor_b_err", {31'd0, addr_err}, 32'd1);

    // Disabled request has no side effect; simultaneous independent reads
    a_en = 1'b0; a_write = 1'b1; a_addr = 9'h003; a_din = 32'h1234_5678; a_be = 4'hF;
    tick();
    a_write = 1'b0;
    a_en = 1'b1; a_addr = 9'h010; b_en = 1'b1; b_addr = 9'h003;
    tick();
    a_en = 1'b0; b_en = 1'b0;
    check("dual_a", a_dout, 32'hAA22_CC44);
    check("dual_b", b_dout, 32'h0000_0005);
    check("dual_a_v", {31'd0, a_valid}, 32'd1);
    check("dual_b_v", {31'd0, b_valid}, 32'd1);

    // Reset right after an accepted read
    a_rd(9'h010);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, a_valid}, 32'd0);
    check("mid_rst_a_dout", a_dout, 32'h0);
    check("mid_rst_b_dout", b_dout, 32'h0);
    check("mid_rst_busy", {31'd0, busy}, 32'd1);
    tick();
    reset_n = 1'b1;
    check("rel_busy", {31'd0, busy}, 32'd1);
    // Request while busy must be ignored
    a_en = 1'b1; a_write = 1'b0; a_addr = 9'h003;
    tick();
    a_en = 1'b0;
    check("busy_ignore_v", {31'd0, a_valid}, 32'd0);
    check("busy_ignore_d", a_dout, 32'h0);
    wait_ready(n);
    check("post_rel_valid", {31'd0, a_valid}, 32'd0);
    a_rd(9'h003);
`ifdef RAM_CLEAR_EN
    check("post_rst_rd", a_dout, 32'h0);
`else
    check("post_rst_rd", a_dout, 32'h0000_0005);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
